// File: rtl/alu_flag_writeback_if.sv
// alu_flag_writeback_if
//   Bundles the two handshake channels of the ALU result stage.
//   Upstream channel (from the add/sub datapath):
//     in_valid, in_ready, in_a[63:0], in_b[63:0], in_sel, in_result[63:0]
//   Downstream channel (toward the writeback consumer):
//     out_valid, out_ready, out_result[63:0], out_flags[3:0] = {N, Z, C, V}
//   Modports:
//     slave  - the result stage: consumes in_*, produces out_*.
//     master - the environment: drives in_* and out_ready.
interface alu_flag_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sel;
  logic [63:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_flags;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_result, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, in_result, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback
//   Registered result stage behind the 64-bit add/sub datapath. Captures the
//   adder result with its operands and op select, derives N/Z/C/V flags and
//   buffers {result, flags} in a DEPTH-entry FIFO toward writeback.
//
//   Parameters:
//     DEPTH       FIFO entries, power of two, >= 2.
//   Ports:
//     clk         rising-edge clock.
//     rst_n       asynchronous active-low reset.
//     bus         alu_flag_writeback_if.slave (both handshake channels).
//     sticky_clr  synchronous clear of sticky overflow state.
//     sticky_v    sticky signed-overflow flag.
//     ovf_count   saturating count of overflowing pushes.
//
//   Optional feature: define ALU_STICKY_FLAGS_EN to build the sticky overflow
//   flag and counter. Without it sticky_clr is ignored and sticky_v/ovf_count
//   are tied to 0.
module alu_flag_writeback #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_flag_writeback_if.slave  bus,
  input  logic                 sticky_clr,
  output logic                 sticky_v,
  output logic [15:0]          ovf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // ---------------------------------------------------------------------------
  // Flag derivation from the incoming bundle. Only the MSBs of the operands
  // matter: the carry-out is reconstructed from the top bit of A, the top bit
  // of the (possibly inverted) B and the top bit of the sum.
  // ---------------------------------------------------------------------------
  logic   a_msb;
  logic   b_msb;
  logic   r_msb;
  flags_t in_flags;

  assign a_msb = bus.in_a[63];
  assign b_msb = bus.in_b[63] ^ bus.in_sel;  // SUB feeds ~B to the adder
  assign r_msb = bus.in_result[63];

  // NOTE: every output of an always_comb is assigned on every path (here a
  // default first), otherwise synthesis infers a latch.
  always_comb begin
    in_flags   = '0;
    in_flags.n = r_msb;
    in_flags.z = (bus.in_result == 64'd0);
    in_flags.c = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~r_msb);
    in_flags.v = ~(a_msb ^ b_msb) & (a_msb ^ r_msb);
  end

  // Low operand bits feed the adder, not this stage.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.in_a[62:0], bus.in_b[62:0]};

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);  // DEPTH is a power of two: natural wrap
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Entries are only observed while count says they are valid, and
  // the empty-state output comes from the hold registers below.
  // NOTE: the storage array is deliberately not reset; it holds no control
  // state, so it can map to plain flops/RAM without reset routing.
  // ---------------------------------------------------------------------------
  logic [63:0] result_mem [DEPTH];
  flags_t      flags_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= bus.in_result;
      flags_mem[wr_ptr]  <= in_flags;
    end
  end

  // Last popped entry, presented while empty; also provides the zero output
  // after reset without resetting the array.
  logic [63:0] hold_result;
  flags_t      hold_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_result <= '0;
      hold_flags  <= '0;
    end else if (pop) begin
      hold_result <= result_mem[rd_ptr];
      hold_flags  <= flags_mem[rd_ptr];
    end
  end

  assign bus.out_result = bus.out_valid ? result_mem[rd_ptr] : hold_result;
  assign bus.out_flags  = bus.out_valid ? flags_mem[rd_ptr]  : hold_flags;

  // ---------------------------------------------------------------------------
  // Sticky overflow flag and saturating counter
  // ---------------------------------------------------------------------------
`ifdef ALU_STICKY_FLAGS_EN
  logic        ovf_push;
  logic        sticky_q;
  logic [15:0] ovf_q;

  assign ovf_push = push && in_flags.v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      ovf_q    <= '0;
    end else if (sticky_clr) begin
      // A same-cycle overflow survives the clear as the first new event.
      sticky_q <= ovf_push;
      ovf_q    <= {15'd0, ovf_push};
    end else if (ovf_push) begin
      sticky_q <= 1'b1;
      if (ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  assign sticky_v  = sticky_q;
  assign ovf_count = ovf_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_v          = 1'b0;
  assign ovf_count         = 16'd0;
`endif

endmodule

// File: tb/tb_alu_flag_writeback.sv
// tb_alu_flag_writeback
//   Self-checking bench for alu_flag_writeback (DEPTH=2): flag vectors from a
//   table, then hand-written sequences for backpressure, streaming with
//   pointer wrap, asynchronous reset mid-stream and (when ALU_STICKY_FLAGS_EN
//   is defined) the sticky overflow flag/counter.
module tb_alu_flag_writeback;

  logic        clk;
  logic        rst_n;
  logic        sticky_clr;
  logic        sticky_v;
  logic [15:0] ovf_count;

  int checks;
  int failures;

  alu_flag_writeback_if bus ();

  alu_flag_writeback #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sticky_clr (sticky_clr),
    .sticky_v   (sticky_v),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sel;
    logic [63:0] result;
    logic [3:0]  flags;  // {N, Z, C, V}
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [63:0] a, input logic [63:0] b,
                       input logic sel, input logic [63:0] result);
    bus.in_valid  = valid;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sel    = sel;
    bus.in_result = result;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd8, 4'b0000};
    vecs[1] = '{64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[2] = '{64'd7, 64'd7, 1'b1, 64'd0, 4'b0110};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110};
    vecs[5] = '{64'd5, 64'd3, 1'b1, 64'd2, 4'b0010};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};

    checks        = 0;
    failures      = 0;
    sticky_clr    = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    check("rst_sticky_v", 64'(sticky_v), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Flag vectors: push, check head one cycle later, then pop.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].result);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0);
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].result);
      check($sformatf("vec%0d_flags", i), 64'(bus.out_flags), 64'(vecs[i].flags));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_popped", i), 64'(bus.out_valid), 64'd0);
    end

    // Backpressure: three back-to-back pushes into DEPTH=2 with out_ready low.
    drive(1'b1, 64'd1, 64'd1, 1'b0, 64'd100);
    tick();
    check("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 64'd1, 64'd1, 1'b0, 64'd101);
    tick();
    check("bp_ready_after_2", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 64'd1, 64'd1, 1'b0, 64'd102);
    tick();
    check("bp_ready_still_low", 64'(bus.in_ready), 64'd0);
    check("bp_head_stable", bus.out_result, 64'd100);
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_ready", 64'(bus.in_ready), 64'd1);
    check("bp_pop1_valid", 64'(bus.out_valid), 64'd1);
    check("bp_pop1_result", bus.out_result, 64'd101);
    tick();
    check("bp_third_dropped", 64'(bus.out_valid), 64'd0);
    check("bp_hold_last", bus.out_result, 64'd101);

    // Streaming with out_ready high: one output per cycle, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'd0, 64'd0, 1'b0, 64'(200 + i));
      tick();
      check($sformatf("stream%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("stream%0d_result", i), bus.out_result, 64'(200 + i));
      check($sformatf("stream%0d_ready", i), 64'(bus.in_ready), 64'd1);
    end

    // Asynchronous reset mid-stream (between clock edges).
    drive(1'b1, 64'd0, 64'd0, 1'b0, 64'd300);
    bus.out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_result", bus.out_result, 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0);
    #3;
    rst_n = 1'b1;
    tick();
    check("post_rst_empty", 64'(bus.out_valid), 64'd0);

`ifdef ALU_STICKY_FLAGS_EN
    // Three overflowing ADDs.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    check("sticky_set", 64'(sticky_v), 64'd1);
    check("ovf_count_3", 64'(ovf_count), 64'd3);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared", 64'(sticky_v), 64'd0);
    check("ovf_count_cleared", 64'(ovf_count), 64'd0);
    // Clear coinciding with an overflowing push.
    sticky_clr = 1'b1;
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000);
    tick();
    sticky_clr = 1'b0;
    check("clr_push_sticky", 64'(sticky_v), 64'd1);
    check("clr_push_count", 64'(ovf_count), 64'd1);
    // Run the counter up to saturation, then one more.
    for (int i = 0; i < 65534; i++) tick();
    check("ovf_count_max", 64'(ovf_count), 64'hFFFF);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    check("ovf_count_saturated", 64'(ovf_count), 64'hFFFF);
`else
    // Feature absent: clear input has no effect and outputs stay 0.
    bus.out_ready = 1'b1;
    sticky_clr    = 1'b1;
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000);
    tick();
    sticky_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    check("nosticky_v", 64'(sticky_v), 64'd0);
    check("nosticky_count", 64'(ovf_count), 64'd0);
    check("nosticky_flags", 64'(bus.out_flags), 64'b1001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_flag_writeback.md
# alu_flag_writeback

Registered result stage directly downstream of the 64-bit add/sub datapath. Captures the adder's combinational result together with the operands and op select that produced it, derives N/Z/C/V condition flags, and buffers result plus flags in a small FIFO with valid/ready handshakes toward the writeback consumer. Isolates the long ripple-carry path from downstream timing.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/result bundle valid.
- in_ready  out  1  stage can accept; high iff occupancy < DEPTH.
- in_a  in  64  operand A as presented to the adder.
- in_b  in  64  operand B (un-inverted) as presented to the adder.
- in_sel  in  1  0 = ADD, 1 = SUB (adder uses ~B and carry-in 1).
- in_result  in  64  adder Result for in_a/in_b/in_sel.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_result  out  64  head result.
- out_flags  out  4  head flags {N, Z, C, V}.
- sticky_clr  in  1  clear sticky overflow state (macro only).
- sticky_v  out  1  sticky signed-overflow flag (macro only).
- ovf_count  out  16  overflow event counter (macro only).

## Operation
- Push on in_valid && in_ready; pop on out_valid && out_ready.
- Flags computed combinationally from the input bundle at push time and stored with the result; Bs = in_sel ? ~in_b : in_b.
  - N = in_result[63]; Z = (in_result == 0).
  - C = (in_a[63] & Bs[63]) | ((in_a[63] ^ Bs[63]) & ~in_result[63]) — true carry-out; for SUB, C=1 means no borrow (A ≥ B unsigned).
  - V = ~(in_a[63] ^ Bs[63]) & (in_a[63] ^ in_result[63]).
- FIFO: circular buffer, log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- Simultaneous push and pop: occupancy unchanged, both pointers advance; when full, in_ready is low so no push occurs even if a pop happens the same cycle.
- Empty: out_valid low; out_result/out_flags hold last popped entry (don't-care to consumer).
- Result and flags are not modified by the stage; in_result is trusted, not recomputed.

## Timing
- Latency: push in cycle n → out_valid high in cycle n+1 (empty case); no combinational in→out path.
- in_ready depends only on registered occupancy (no combinational dependency on out_ready).
- out_valid, out_result, out_flags driven from registers/FIFO storage; stable while out_valid && !out_ready.
- Throughput: one bundle per cycle sustained when out_ready held high.
- Reset (asynchronous, any cycle, including mid-transfer): occupancy 0, pointers 0, out_valid 0, in_ready 1, out_result 0, out_flags 0, sticky_v 0, ovf_count 0; in-flight entries discarded.

## Configuration
- ALU_STICKY_FLAGS_EN defined: on every push with V=1, sticky_v sets and ovf_count increments, saturating at 16'hFFFF. sticky_clr (synchronous) clears both; clear in same cycle as an overflowing push → sticky_v=1, ovf_count=1.
- Not defined: sticky_clr ignored, sticky_v and ovf_count tied to 0; no sticky/counter registers built.

## Test plan
- ADD A=5, B=3, sel=0, Result=8 → next cycle out_valid=1, out_result=8, flags N=0 Z=0 C=0 V=0.
- SUB A=3, B=5, sel=1, Result=64'hFFFF_FFFF_FFFF_FFFE → flags N=1 Z=0 C=0 V=0; SUB A=B=7, Result=0 → Z=1, C=1.
- ADD A=64'h7FFF_FFFF_FFFF_FFFF, B=1, Result=64'h8000_0000_0000_0000 → N=1 V=1 C=0; ADD A=64'hFFFF_FFFF_FFFF_FFFF, B=1, Result=0 → Z=1 C=1 V=0.
- DEPTH=2, out_ready=0, push 3 bundles back-to-back → in_ready low after 2nd push, 3rd not accepted; raise out_ready → entries drain in order, in_ready high one cycle after first pop.
- Continuous push/pop with out_ready=1 for 10 cycles → one output per cycle, pointers wrap, order preserved; assert rst_n low mid-stream → out_valid=0, in_ready=1 immediately.
- With ALU_STICKY_FLAGS_EN: 3 overflowing ADDs → sticky_v=1, ovf_count=3; pulse sticky_clr → both 0; preload count 16'hFFFF via overflows, one more → stays 16'hFFFF.
